// File: rtl/phy_pkg.sv
// phy_pkg: lane symbols and receive FSM encodings shared by the PHY transmitter and receiver
package phy_pkg;
  localparam logic [7:0] COMMA_DEFAULT = 8'hBC;
  typedef enum logic [1:0] {SEARCH = 2'd0, ALIGN = 2'd1, ACTIVE = 2'd2} phy_state_t;
endpackage

// File: rtl/phy_rx_deser.sv
// phy_rx_deser: serial-to-parallel shifter with an aligned bit counter and byte-complete flag
module phy_rx_deser (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_serial,
  input  logic       search,
  output logic [7:0] byte_val,
  output logic       done
);
  logic [7:0] sr;
  logic [2:0] cnt;
  assign byte_val = sr;
  // The counter is pinned to zero while searching, so the cycle after a comma match starts a fresh byte.
  assign done = !search && cnt == 3'd7;
  always_ff @(posedge clk_32f or posedge reset)
    if (reset) begin
      sr  <= 8'h00;
      cnt <= 3'd0;
    end else begin
      sr  <= {sr[6:0], data_serial};
      cnt <= search ? 3'd0 : cnt + 3'd1;
    end
endmodule

// File: rtl/phy_rx_lane.sv
// phy_rx_lane: comma-aligned serial receive lane; define PHY_RX_IDLE_CNT_EN to add the idle_cnt output
module phy_rx_lane import phy_pkg::*; #(
  parameter logic [7:0]  COMMA        = COMMA_DEFAULT,
  parameter int unsigned BC_THRESHOLD = 4
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic        data_serial,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        byte_strobe,
  output logic        active
`ifdef PHY_RX_IDLE_CNT_EN
  , output logic [15:0] idle_cnt
`endif
);
  localparam logic       th_one = BC_THRESHOLD == 1;
  localparam logic [3:0] th_cnt = 4'(BC_THRESHOLD);
  phy_state_t state;
  logic [3:0] bc_count;
  logic [7:0] byte_val;
  logic       done;
  logic       is_comma;
  phy_rx_deser u_deser (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_serial(data_serial),
    .search     (state == SEARCH),
    .byte_val   (byte_val),
    .done       (done)
  );
  assign is_comma = byte_val == COMMA;
  always_ff @(posedge clk_32f or posedge reset)
    if (reset) begin
      state       <= SEARCH;
      bc_count    <= 4'd0;
      data_out    <= 8'h00;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
      active      <= 1'b0;
    end else begin
      byte_strobe <= done;
      if (done) begin
        data_out  <= byte_val;
        valid_out <= state == ACTIVE && !is_comma;
      end
      if (state == SEARCH && is_comma) begin
        bc_count <= 4'd1;
        state    <= th_one ? ACTIVE : ALIGN;
        active   <= th_one;
      end else if (state == ALIGN && done) begin
        bc_count <= is_comma ? bc_count + 4'd1 : 4'd0;
        if (!is_comma)
          state <= SEARCH;
        else if (bc_count + 4'd1 == th_cnt) begin
          state  <= ACTIVE;
          active <= 1'b1;
        end
      end
    end
`ifdef PHY_RX_IDLE_CNT_EN
  always_ff @(posedge clk_32f or posedge reset)
    if (reset)
      idle_cnt <= 16'd0;
    else if (done && state == ACTIVE && is_comma && idle_cnt != 16'hFFFF)
      idle_cnt <= idle_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_phy_rx_lane.sv
// tb_phy_rx_lane: drives bit streams into phy_rx_lane and checks every cycle against a stream-level model
module tb_phy_rx_lane;
  localparam logic [7:0] COMMA = 8'hBC;
  localparam int TH = 4;
  logic clk_32f = 1'b0;
  logic reset = 1'b1;
  logic data_serial = 1'b0;
  logic [7:0] data_out;
  logic valid_out, byte_strobe, active;
`ifdef PHY_RX_IDLE_CNT_EN
  logic [15:0] idle_cnt;
`endif
  int errors = 0;
  int checks = 0;
  bit chk = 1'b1;
  logic [7:0] w;
  bit m_aligned;
  int n, commas;
  logic e_strobe, e_valid, e_active;
  logic [7:0] e_data;
  logic [15:0] m_idle;

  phy_rx_lane #(.COMMA(COMMA), .BC_THRESHOLD(TH)) dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_serial(data_serial),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .byte_strobe(byte_strobe),
    .active     (active)
`ifdef PHY_RX_IDLE_CNT_EN
    , .idle_cnt (idle_cnt)
`endif
  );

  always #5 clk_32f = ~clk_32f;

  initial begin
`ifdef PHY_RX_IDLE_CNT_EN
    #10_000_000;
`else
    #1_000_000;
`endif
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic model_reset();
    w = 8'h00; m_aligned = 0; n = 0; commas = 0;
    e_strobe = 0; e_valid = 0; e_active = 0; e_data = 8'h00; m_idle = 16'h0000;
  endtask

  // Model view: the lane locks on the first window equal to COMMA, then every 8 further bits form a byte,
  // whose outputs appear one clock after its last bit was sampled.
  task automatic step(input logic b);
    data_serial = b;
    @(posedge clk_32f);
    #1;
    if (chk) begin
      checks += 4;
      if (byte_strobe !== e_strobe) begin errors++; $display("FAIL strobe t=%0t got %b exp %b", $time, byte_strobe, e_strobe); end
      if (data_out !== e_data) begin errors++; $display("FAIL data_out t=%0t got %h exp %h", $time, data_out, e_data); end
      if (valid_out !== e_valid) begin errors++; $display("FAIL valid_out t=%0t got %b exp %b", $time, valid_out, e_valid); end
      if (active !== e_active) begin errors++; $display("FAIL active t=%0t got %b exp %b", $time, active, e_active); end
    end
    w = {w[6:0], b};
    e_strobe = 0;
    if (!m_aligned) begin
      if (w == COMMA) begin
        m_aligned = 1; n = 0; commas = 1;
        if (TH == 1) e_active = 1;
      end
    end else begin
      n++;
      if (n == 8) begin
        n = 0;
        e_strobe = 1;
        e_data = w;
        e_valid = e_active && w != COMMA;
        if (e_active) begin
          if (w == COMMA && m_idle != 16'hFFFF) m_idle++;
        end else if (w == COMMA) begin
          commas++;
          if (commas == TH) e_active = 1;
        end else begin
          m_aligned = 0; commas = 0;
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) step(v[i]);
  endtask

  task automatic check_zero(input string tag);
    checks += 4;
    if (data_out !== 8'h00) begin errors++; $display("FAIL %s data_out got %h exp 00", tag, data_out); end
    if (valid_out !== 1'b0) begin errors++; $display("FAIL %s valid_out got %b exp 0", tag, valid_out); end
    if (byte_strobe !== 1'b0) begin errors++; $display("FAIL %s strobe got %b exp 0", tag, byte_strobe); end
    if (active !== 1'b0) begin errors++; $display("FAIL %s active got %b exp 0", tag, active); end
`ifdef PHY_RX_IDLE_CNT_EN
    checks++;
    if (idle_cnt !== 16'h0000) begin errors++; $display("FAIL %s idle_cnt got %h exp 0000", tag, idle_cnt); end
`endif
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    check_zero(tag);
    @(posedge clk_32f);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset("reset");
  endtask

  task automatic test_lock();
    repeat (4) send_byte(COMMA);
    send_byte(8'hA5);
    send_byte(8'h00);
    checks += 3;
    if (data_out !== 8'hA5) begin errors++; $display("FAIL lock data_out got %h exp a5", data_out); end
    if (valid_out !== 1'b1) begin errors++; $display("FAIL lock valid_out got %b exp 1", valid_out); end
    if (active !== 1'b1) begin errors++; $display("FAIL lock active got %b exp 1", active); end
  endtask

  task automatic test_realign();
    do_reset("realign_reset");
    repeat (3) step(1'($urandom_range(0, 1)));
    send_byte(COMMA);
    send_byte(COMMA);
    send_byte(8'h3C);
    step(1'b0);
    checks++;
    if (active !== 1'b0) begin errors++; $display("FAIL realign active_after_3c got %b exp 0", active); end
    repeat (7) step(1'b0);
    repeat (4) send_byte(COMMA);
    send_byte(8'h5A);
    checks += 2;
    if (active !== 1'b1) begin errors++; $display("FAIL realign active got %b exp 1", active); end
    if (data_out !== COMMA) begin errors++; $display("FAIL realign data_out got %h exp bc", data_out); end
  endtask

  task automatic test_data();
    send_byte(8'h12);
    send_byte(COMMA);
    send_byte(8'h34);
    send_byte(8'h00);
    checks += 2;
    if (data_out !== 8'h34) begin errors++; $display("FAIL data data_out got %h exp 34", data_out); end
    if (valid_out !== 1'b1) begin errors++; $display("FAIL data valid_out got %b exp 1", valid_out); end
  endtask

  task automatic test_straddle();
    send_byte(8'h0B);
    send_byte(8'hC0);
    send_byte(8'h77);
    checks += 3;
    if (data_out !== 8'hC0) begin errors++; $display("FAIL straddle data_out got %h exp c0", data_out); end
    if (valid_out !== 1'b1) begin errors++; $display("FAIL straddle valid_out got %b exp 1", valid_out); end
    if (active !== 1'b1) begin errors++; $display("FAIL straddle active got %b exp 1", active); end
  endtask

  task automatic test_reset_mid();
    repeat (4) step(1'b1);
    do_reset("reset_mid");
    repeat (4) send_byte(COMMA);
    send_byte(8'h66);
    checks++;
    if (active !== 1'b1) begin errors++; $display("FAIL reset_mid active got %b exp 1", active); end
  endtask

  task automatic test_random();
    do_reset("random_reset");
    repeat ($urandom_range(1, 20)) step(1'($urandom_range(0, 1)));
    repeat (4) send_byte(COMMA);
    for (int i = 0; i < 40; i++)
      send_byte(($urandom_range(0, 3) == 0) ? COMMA : 8'($urandom));
    repeat (8) step(1'b0);
`ifdef PHY_RX_IDLE_CNT_EN
    checks++;
    if (idle_cnt !== m_idle) begin errors++; $display("FAIL random idle_cnt got %h exp %h", idle_cnt, m_idle); end
`endif
  endtask

`ifdef PHY_RX_IDLE_CNT_EN
  task automatic test_idle();
    do_reset("idle_reset");
    repeat (4) send_byte(COMMA);
    chk = 1'b0;
    repeat (70000) send_byte(COMMA);
    chk = 1'b1;
    send_byte(8'hA5);
    send_byte(8'h00);
    checks += 2;
    if (idle_cnt !== m_idle) begin errors++; $display("FAIL idle model got %h exp %h", idle_cnt, m_idle); end
    if (idle_cnt !== 16'hFFFF) begin errors++; $display("FAIL idle saturate got %h exp ffff", idle_cnt); end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_lock();
    test_realign();
    test_data();
    test_straddle();
    test_reset_mid();
    test_random();
`ifdef PHY_RX_IDLE_CNT_EN
    test_idle();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/phy_rx_lane.md
PHY_RX_LANE -- requirements
Module: phy_rx_lane

Interface
REQ-001 SHALL have parameter COMMA, default 8'hBC: idle/alignment symbol emitted by the transmitter when there is no valid data.
REQ-002 SHALL have parameter BC_THRESHOLD, default 4: count of consecutive aligned COMMA bytes needed to declare the lane active (legal range 1..15).
REQ-003 SHALL have port clk_32f, input, 1 bit: the single clock, one serial bit per rising edge; all logic is in this clock domain.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port data_serial, input, 1 bit: serial lane data, MSB of each byte first.
REQ-006 SHALL have port data_out, output, 8 bits: the last deserialized byte.
REQ-007 SHALL have port valid_out, output, 1 bit: data_out is a non-COMMA byte received while active.
REQ-008 SHALL have port byte_strobe, output, 1 bit: one-cycle pulse marking each completed aligned byte.
REQ-009 SHALL have port active, output, 1 bit: the lane is aligned and has met the COMMA threshold.

Function
REQ-010 SHALL shift data_serial into an 8-bit register each cycle (left shift, new bit enters LSB), independent of state.
REQ-011 SHALL implement FSM states SEARCH, ALIGN and ACTIVE, with SEARCH as the reset state.
REQ-012 In SEARCH, SHALL compare the post-shift register with COMMA every cycle; on a match: clear the bit counter, set bc_count=1 and go to ALIGN (or to ACTIVE if BC_THRESHOLD==1).
REQ-013 Outside SEARCH, SHALL use a 3-bit bit counter that wraps 7->0; a byte completes on the cycle its 8th bit is shifted in.
REQ-014 In ALIGN, on a completed COMMA byte: increment bc_count; on reaching BC_THRESHOLD go to ACTIVE.
REQ-015 In ALIGN, on a completed non-COMMA byte: go to SEARCH and clear bc_count.
REQ-016 In ACTIVE, SHALL stay in ACTIVE for any byte value; only reset leaves ACTIVE.
REQ-017 Latency: byte_strobe, data_out and valid_out SHALL update on the edge after the byte's last bit is sampled; data_out and valid_out hold until the next strobe.
REQ-018 byte_strobe SHALL pulse for every completed byte in ALIGN and ACTIVE, and never in SEARCH.
REQ-019 valid_out SHALL be 1 only for strobed non-COMMA bytes while ACTIVE, and 0 for COMMA bytes and in every other state.
REQ-020 active SHALL be registered and rise together with the strobe of the threshold-reaching COMMA byte.
REQ-021 A COMMA pattern straddling byte boundaries in ALIGN or ACTIVE SHALL NOT cause realignment.

Reset
REQ-022 While reset is high: state=SEARCH, shift register=0, bit counter=0, bc_count=0, data_out=8'h00, valid_out=0, byte_strobe=0, active=0; takes effect immediately, without waiting for a clock edge.
REQ-023 Reset asserted mid-byte or while ACTIVE SHALL discard the partial byte; after release, alignment restarts from SEARCH.

Configuration
REQ-024 With macro PHY_RX_IDLE_CNT_EN defined, SHALL add output idle_cnt[15:0]: a count of COMMA bytes strobed while ACTIVE, saturating at 16'hFFFF and cleared by reset.
REQ-025 Without PHY_RX_IDLE_CNT_EN, neither the idle_cnt port nor its counter logic SHALL exist; all other behaviour is identical.

Structure
REQ-026 The COMMA default value and the FSM state encodings (SEARCH=2'd0, ALIGN=2'd1, ACTIVE=2'd2) SHALL live in the shared package/include phy_pkg, also used by the transmitter.
REQ-027 The shift register, bit counter and byte-complete generation SHALL be the sub-module phy_rx_deser; the FSM and outputs stay in phy_rx_lane.

Verification
REQ-028 After reset, send 4x 8'hBC, then 8'hA5 -> active rises on the 4th BC strobe; the next strobe gives data_out=8'hA5, valid_out=1.
REQ-029 Send 3 junk bits, then 8'hBC, 8'hBC, 8'h3C, then 4x 8'hBC -> alignment is lost on 8'h3C with active=0; after re-searching, active=1 only after the later 4 BCs.
REQ-030 While ACTIVE, send 8'h12, 8'hBC, 8'h34 -> strobes give (12,valid 1), (BC,valid 0), (34,valid 1) at 8-cycle spacing.
REQ-031 While ACTIVE, assert reset at bit 4 of a byte for 1 cycle -> all outputs go to 0 immediately; the bench realigns after 4 new BCs.
REQ-032 With PHY_RX_IDLE_CNT_EN defined, send 70000 BCs while ACTIVE -> idle_cnt saturates at 16'hFFFF; a later data byte leaves it at 16'hFFFF.
REQ-033 While ACTIVE, send 8'h0B then 8'hC0 (bit stream contains BC across the boundary) -> no realignment; strobes give 0B and C0, both with valid_out=1.
